operand_stage_queue: RTL and testbench
======================================

OPERAND_STAGE_QUEUE -- requirements
Module: operand_stage_queue

Interface
REQ-001 SHALL have parameter DISPATCH_WIDTH, default 2: enqueue lanes per cycle.
REQ-002 SHALL have parameter DEPTH, default 8, power of two and at least DISPATCH_WIDTH: entry count.
REQ-003 SHALL have parameter WB_WIDTH, default 2: writeback wakeup ports.
REQ-004 SHALL have parameter PHYS_REGS_ADDR_WIDTH, default 6: physical tag width.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports:
- dispatch_valid  in  [DISPATCH_WIDTH]x1  lane valid.
- op1_type, op2_type  in  [DISPATCH_WIDTH]x$bits(common::op_type_t)  operand kind.
- rs1, rs2  in  [DISPATCH_WIDTH]xPHYS_REGS_ADDR_WIDTH  source tags.
- rs1_valid, rs2_valid  in  [DISPATCH_WIDTH]x1  source already available.
- imm  in  [DISPATCH_WIDTH]x32  immediate.
- dispatch_ready  out  1  queue accepts a full dispatch group.
- wb_valid  in  [WB_WIDTH]x1  wakeup valid.
- wb_tag  in  [WB_WIDTH]xPHYS_REGS_ADDR_WIDTH  wakeup tag.
- wb_data  in  [WB_WIDTH]x32  wakeup value.
- issue_valid  out  1  head entry ready.
- issue_ready  in  1  consumer accepts.
- issue_op1, issue_op2  out  32  head operands.
- count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-007 SHALL store per entry op1/op2 as a 32-bit field plus a ready bit; the field holds the zero-extended tag while not ready and the data once ready.
REQ-008 Capture per operand SHALL be: REG -> tag, ready = rsN_valid; IMM -> imm, ready = 1; any other type -> 0, ready = 1.
REQ-009 At capture, a REG operand that is not ready and whose tag matches a same-cycle wb_valid port SHALL be stored with that wb_data and ready = 1.
REQ-010 A stored operand that is not ready SHALL, on a wb tag match, take wb_data and set ready at the next edge; a ready operand SHALL ignore wakeups.
REQ-011 If several wb ports match one operand, the lowest-index port SHALL win.
REQ-012 dispatch_valid SHALL be contiguous from lane 0; lane i SHALL write entry (tail+i) mod DEPTH; tail and count SHALL advance by the number of valid lanes.
REQ-013 dispatch_ready SHALL equal (DEPTH - count) >= DISPATCH_WIDTH, computed from registered count only (a same-cycle pop does not free space); dispatch while !dispatch_ready SHALL be ignored.
REQ-014 issue_valid SHALL be count != 0 and both head ready bits registered set; a same-cycle wakeup SHALL NOT raise issue_valid (wakeup-to-issue latency 1 cycle).
REQ-015 issue_op1/issue_op2 SHALL show the head fields whenever count != 0, else 0.
REQ-016 issue_valid && issue_ready SHALL pop the head: head+1 mod DEPTH, count-1; simultaneous push and pop SHALL give count + pushed - 1.
REQ-017 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.

Reset
REQ-018 rst SHALL clear head, tail, count and all ready bits at the next edge, overriding push, pop and wakeup; outputs after reset: issue_valid 0, dispatch_ready 1, count 0, issue_op1/op2 0.

Configuration
REQ-019 With OPQ_FLUSH_EN defined, SHALL add input flush (1 bit); flush SHALL clear head, tail, count and ready bits at the next edge, taking priority over push, pop and wakeup and yielding to rst.
REQ-020 Without OPQ_FLUSH_EN, the flush port and its logic SHALL be absent; behaviour otherwise identical.

Verification
REQ-021 Reset -> count 0, issue_valid 0, dispatch_ready 1.
REQ-022 Dispatch lane0 op1 IMM 0x10, op2 REG tag 5 with rs2_valid 0; next cycle wb tag 5 data 0xABCD -> the following cycle issue_valid 1, op1 0x10, op2 0xABCD.
REQ-023 Dispatch REG tag 7 with rs_valid 0 while wb tag 7 data 0x55 is in the same cycle -> stored ready; issue_valid 1 in the next cycle.
REQ-024 Fill to DEPTH=8 with issue_ready 0 -> dispatch_ready 0 at count 7 and 8; push while full is ignored; pop then push crosses pointer wrap and preserves FIFO order.
REQ-025 Head not ready while second entry ready -> no issue (in-order); wb ports 0 and 1 both match the head tag with data 0x1 and 0x2 -> head takes 0x1.
REQ-026 OPQ_FLUSH_EN: count 4, flush with concurrent push and pop -> count 0 and issue_valid 0 next cycle.

Source files
------------

// File: rtl/operand_stage_queue.sv
`default_nettype none
// ============================================================================
// Module   : operand_stage_queue (+ package common)
// Purpose  : In-order operand staging FIFO with writeback wakeup and capture
//            bypass. Optional flush input enabled by defining OPQ_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================

package common;
    typedef enum logic [1:0] {
        OP_REG  = 2'd0,
        OP_IMM  = 2'd1,
        OP_PC   = 2'd2,
        OP_NONE = 2'd3
    } op_type_t;
endpackage

module operand_stage_queue #(
    parameter int DISPATCH_WIDTH       = 2,
    parameter int DEPTH                = 8,
    parameter int WB_WIDTH             = 2,
    parameter int PHYS_REGS_ADDR_WIDTH = 6
) (
    input  logic                                                     clk,
    input  logic                                                     rst,
`ifdef OPQ_FLUSH_EN
    input  logic                                                     flush,
`endif
    input  logic [DISPATCH_WIDTH-1:0]                                dispatch_valid,
    input  logic [DISPATCH_WIDTH-1:0][$bits(common::op_type_t)-1:0]  op1_type,
    input  logic [DISPATCH_WIDTH-1:0][$bits(common::op_type_t)-1:0]  op2_type,
    input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]      rs1,
    input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]      rs2,
    input  logic [DISPATCH_WIDTH-1:0]                                rs1_valid,
    input  logic [DISPATCH_WIDTH-1:0]                                rs2_valid,
    input  logic [DISPATCH_WIDTH-1:0][31:0]                          imm,
    output logic                                                     dispatch_ready,
    input  logic [WB_WIDTH-1:0]                                      wb_valid,
    input  logic [WB_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]            wb_tag,
    input  logic [WB_WIDTH-1:0][31:0]                                wb_data,
    output logic                                                     issue_valid,
    input  logic                                                     issue_ready,
    output logic [31:0]                                              issue_op1,
    output logic [31:0]                                              issue_op2,
    output logic [$clog2(DEPTH):0]                                   count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;
    localparam int c_typ_w = $bits(common::op_type_t);
    localparam int c_tag_w = PHYS_REGS_ADDR_WIDTH;

    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;
    logic [31:0]        r_op1 [DEPTH];
    logic [31:0]        r_op2 [DEPTH];
    logic [DEPTH-1:0]   r_rdy1;
    logic [DEPTH-1:0]   r_rdy2;

    logic [31:0]        w_op1_nxt [DEPTH];
    logic [31:0]        w_op2_nxt [DEPTH];
    logic [DEPTH-1:0]   w_rdy1_nxt;
    logic [DEPTH-1:0]   w_rdy2_nxt;
    logic [c_cnt_w-1:0] w_push_n;
    logic [c_cnt_w-1:0] w_free;
    logic               w_pop;

    // Returns {hit, data}; scanning high to low lets the lowest port win.
    function automatic logic [32:0] f_wake(input logic [c_tag_w-1:0] tag);
        logic [32:0] res;
        res = '0;
        for (int w = WB_WIDTH - 1; w >= 0; w--) begin
            if (wb_valid[w] && (wb_tag[w] == tag)) begin
                res = {1'b1, wb_data[w]};
            end
        end
        return res;
    endfunction

    // Returns {ready, field} for a freshly dispatched operand.
    function automatic logic [32:0] f_capture(input logic [c_typ_w-1:0] op_type,
                                              input logic [c_tag_w-1:0] tag,
                                              input logic               src_valid,
                                              input logic [31:0]        imm_val);
        logic [32:0] res;
        logic [32:0] wk;
        res = {1'b1, 32'd0};
        wk  = f_wake(tag);
        if (op_type == common::OP_REG) begin
            if (!src_valid && wk[32]) begin
                res = wk;
            end else begin
                res = {src_valid, 32'(tag)};
            end
        end else if (op_type == common::OP_IMM) begin
            res = {1'b1, imm_val};
        end
        return res;
    endfunction

    assign w_free         = c_cnt_w'(DEPTH) - r_count;
    assign dispatch_ready = (w_free >= c_cnt_w'(DISPATCH_WIDTH));
    assign issue_valid    = (r_count != '0) && r_rdy1[r_head] && r_rdy2[r_head];
    assign issue_op1      = (r_count != '0) ? r_op1[r_head] : 32'd0;
    assign issue_op2      = (r_count != '0) ? r_op2[r_head] : 32'd0;
    assign count          = r_count;
    assign w_pop          = issue_valid && issue_ready;

    always_comb begin
        w_push_n = '0;
        if (dispatch_ready) begin
            for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                w_push_n = w_push_n + c_cnt_w'(dispatch_valid[i]);
            end
        end
    end

    always_comb begin
        w_op1_nxt  = r_op1;
        w_op2_nxt  = r_op2;
        w_rdy1_nxt = r_rdy1;
        w_rdy2_nxt = r_rdy2;
        // Waiting operands hold their tag in the low field bits.
        for (int e = 0; e < DEPTH; e++) begin
            if (!r_rdy1[e] && f_wake(r_op1[e][c_tag_w-1:0])[32]) begin
                w_op1_nxt[e]  = f_wake(r_op1[e][c_tag_w-1:0])[31:0];
                w_rdy1_nxt[e] = 1'b1;
            end
            if (!r_rdy2[e] && f_wake(r_op2[e][c_tag_w-1:0])[32]) begin
                w_op2_nxt[e]  = f_wake(r_op2[e][c_tag_w-1:0])[31:0];
                w_rdy2_nxt[e] = 1'b1;
            end
        end
        // Slots being written are free, so capture overrides any wakeup there.
        if (dispatch_ready) begin
            for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                if (dispatch_valid[i]) begin
                    {w_rdy1_nxt[r_tail + c_ptr_w'(i)], w_op1_nxt[r_tail + c_ptr_w'(i)]} =
                        f_capture(op1_type[i], rs1[i], rs1_valid[i], imm[i]);
                    {w_rdy2_nxt[r_tail + c_ptr_w'(i)], w_op2_nxt[r_tail + c_ptr_w'(i)]} =
                        f_capture(op2_type[i], rs2[i], rs2_valid[i], imm[i]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_rdy1  <= '0;
            r_rdy2  <= '0;
        end
`ifdef OPQ_FLUSH_EN
        else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_rdy1  <= '0;
            r_rdy2  <= '0;
        end
`endif
        else begin
            r_head  <= r_head + c_ptr_w'(w_pop);
            r_tail  <= r_tail + c_ptr_w'(w_push_n);
            r_count <= r_count + w_push_n - c_cnt_w'(w_pop);
            r_rdy1  <= w_rdy1_nxt;
            r_rdy2  <= w_rdy2_nxt;
        end
    end

    // Operand fields need no reset: they are only visible while occupied.
    always_ff @(posedge clk) begin
        r_op1 <= w_op1_nxt;
        r_op2 <= w_op2_nxt;
    end

endmodule

`default_nettype wire

// File: tb/tb_operand_stage_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_stage_queue
// Purpose  : Directed and random checks of operand_stage_queue against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_stage_queue;

    localparam int DW    = 2;
    localparam int DEPTH = 8;
    localparam int WB    = 2;
    localparam int TW    = 6;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int TYW   = $bits(common::op_type_t);
`ifdef OPQ_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic [DW-1:0]           dispatch_valid;
    logic [DW-1:0][TYW-1:0]  op1_type, op2_type;
    logic [DW-1:0][TW-1:0]   rs1, rs2;
    logic [DW-1:0]           rs1_valid, rs2_valid;
    logic [DW-1:0][31:0]     imm;
    logic                    dispatch_ready;
    logic [WB-1:0]           wb_valid;
    logic [WB-1:0][TW-1:0]   wb_tag;
    logic [WB-1:0][31:0]     wb_data;
    logic                    issue_valid;
    logic                    issue_ready;
    logic [31:0]             issue_op1, issue_op2;
    logic [CW-1:0]           count;

    int vectors    = 0;
    int miscompares = 0;

    operand_stage_queue #(
        .DISPATCH_WIDTH(DW), .DEPTH(DEPTH), .WB_WIDTH(WB), .PHYS_REGS_ADDR_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst),
`ifdef OPQ_FLUSH_EN
        .flush(flush),
`endif
        .dispatch_valid(dispatch_valid), .op1_type(op1_type), .op2_type(op2_type),
        .rs1(rs1), .rs2(rs2), .rs1_valid(rs1_valid), .rs2_valid(rs2_valid), .imm(imm),
        .dispatch_ready(dispatch_ready), .wb_valid(wb_valid), .wb_tag(wb_tag),
        .wb_data(wb_data), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op1(issue_op1), .issue_op2(issue_op2), .count(count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] v1;
        logic [31:0] v2;
        bit          r1;
        bit          r2;
    } ent_t;

    ent_t mq[$];

    function automatic logic [32:0] m_wake(input logic [31:0] field);
        for (int w = 0; w < WB; w++)
            if (wb_valid[w] && field == {26'd0, wb_tag[w]}) return {1'b1, wb_data[w]};
        return 33'd0;
    endfunction

    function automatic logic [32:0] m_capture(input logic [TYW-1:0] t, input logic [TW-1:0] tag,
                                              input logic v, input logic [31:0] iv);
        logic [32:0] wk;
        if (t == common::OP_REG) begin
            if (v) return {1'b1, 26'd0, tag};
            wk = m_wake({26'd0, tag});
            if (wk[32]) return wk;
            return {1'b0, 26'd0, tag};
        end
        if (t == common::OP_IMM) return {1'b1, iv};
        return {1'b1, 32'd0};
    endfunction

    function automatic logic [69:0] model_exp();
        logic          e_iv, e_dr;
        logic [31:0]   e_o1, e_o2;
        e_dr = (DEPTH - mq.size()) >= DW;
        e_iv = 1'b0; e_o1 = 32'd0; e_o2 = 32'd0;
        if (mq.size() != 0) begin
            e_iv = mq[0].r1 && mq[0].r2;
            e_o1 = mq[0].v1;
            e_o2 = mq[0].v2;
        end
        return {e_iv, e_dr, CW'(mq.size()), e_o1, e_o2};
    endfunction

    function automatic logic [69:0] dut_vec();
        return {issue_valid, dispatch_ready, count, issue_op1, issue_op2};
    endfunction

    task automatic model_step();
        logic [69:0] e;
        logic [32:0] c1, c2, wk;
        ent_t        t;
        bit          do_pop, can_push;
        if (rst || (FLUSH_EN && flush)) begin
            mq.delete();
            return;
        end
        e        = model_exp();
        do_pop   = e[69] && issue_ready;
        can_push = e[68];
        for (int k = 0; k < mq.size(); k++) begin
            t = mq[k];
            if (!t.r1) begin wk = m_wake(t.v1); if (wk[32]) begin t.v1 = wk[31:0]; t.r1 = 1; end end
            if (!t.r2) begin wk = m_wake(t.v2); if (wk[32]) begin t.v2 = wk[31:0]; t.r2 = 1; end end
            mq[k] = t;
        end
        if (do_pop) void'(mq.pop_front());
        if (can_push)
            for (int i = 0; i < DW; i++)
                if (dispatch_valid[i]) begin
                    c1 = m_capture(op1_type[i], rs1[i], rs1_valid[i], imm[i]);
                    c2 = m_capture(op2_type[i], rs2[i], rs2_valid[i], imm[i]);
                    t.v1 = c1[31:0]; t.r1 = c1[32];
                    t.v2 = c2[31:0]; t.r2 = c2[32];
                    mq.push_back(t);
                end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; flush = 0; dispatch_valid = '0; issue_ready = 0; wb_valid = '0;
        for (int i = 0; i < DW; i++) begin
            op1_type[i] = common::OP_NONE; op2_type[i] = common::OP_NONE;
            rs1[i] = '0; rs2[i] = '0; rs1_valid[i] = 0; rs2_valid[i] = 0; imm[i] = '0;
        end
        for (int w = 0; w < WB; w++) begin wb_tag[w] = '0; wb_data[w] = '0; end
    endtask

    task automatic push_imm(input int lanes, input logic [31:0] base);
        for (int i = 0; i < DW; i++) begin
            dispatch_valid[i] = (i < lanes);
            op1_type[i] = common::OP_IMM; op2_type[i] = common::OP_IMM;
            imm[i] = base + 32'(i);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1; issue_ready = 1; dispatch_valid = '1;
        tick(); tick();
        rst = 0; dispatch_valid = '0;
        vectors++;
        if (dut_vec() !== {1'b0, 1'b1, CW'(0), 32'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset: got %h exp %h", dut_vec(), {1'b0, 1'b1, CW'(0), 32'd0, 32'd0});
        end
    endtask

    task automatic test_wakeup();
        idle_inputs();
        dispatch_valid = 2'b01;
        op1_type[0] = common::OP_IMM; imm[0] = 32'h10;
        op2_type[0] = common::OP_REG; rs2[0] = 6'd5; rs2_valid[0] = 0;
        tick();
        idle_inputs();
        vectors++;
        if (dut_vec() !== {1'b0, 1'b1, CW'(1), 32'h10, 32'h5} || dut_vec() !== model_exp()) begin
            miscompares++;
            $display("FAIL wakeup_wait: got %h exp %h", dut_vec(), model_exp());
        end
        wb_valid[0] = 1; wb_tag[0] = 6'd5; wb_data[0] = 32'hABCD;
        #1;
        vectors++;
        if (issue_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wakeup_same_cycle: got %b exp 0", issue_valid);
        end
        tick();
        idle_inputs();
        vectors++;
        if (dut_vec() !== {1'b1, 1'b1, CW'(1), 32'h10, 32'hABCD}) begin
            miscompares++;
            $display("FAIL wakeup_issue: got %h exp %h", dut_vec(), {1'b1, 1'b1, CW'(1), 32'h10, 32'hABCD});
        end
        issue_ready = 1;
        tick();
        vectors++;
        if (dut_vec() !== model_exp() || count !== CW'(0)) begin
            miscompares++;
            $display("FAIL wakeup_pop: got %h exp %h", dut_vec(), model_exp());
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        dispatch_valid = 2'b01;
        op1_type[0] = common::OP_REG; rs1[0] = 6'd7; rs1_valid[0] = 0;
        op2_type[0] = common::OP_PC;
        wb_valid[1] = 1; wb_tag[1] = 6'd7; wb_data[1] = 32'h55;
        tick();
        idle_inputs();
        vectors++;
        if (dut_vec() !== {1'b1, 1'b1, CW'(1), 32'h55, 32'h0} || dut_vec() !== model_exp()) begin
            miscompares++;
            $display("FAIL bypass: got %h exp %h", dut_vec(), {1'b1, 1'b1, CW'(1), 32'h55, 32'h0});
        end
        issue_ready = 1;
        tick();
        issue_ready = 0;
    endtask

    task automatic test_full_wrap();
        idle_inputs();
        // Shift the pointers off zero so a later fill wraps.
        push_imm(1, 32'h900);
        tick();
        idle_inputs(); issue_ready = 1;
        tick();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            push_imm(2, 32'h100 + 32'(k * 16));
            tick();
        end
        idle_inputs();
        vectors++;
        if (count !== CW'(8) || dispatch_ready !== 1'b0 || dut_vec() !== model_exp()) begin
            miscompares++;
            $display("FAIL full8: got %h exp %h", dut_vec(), model_exp());
        end
        push_imm(2, 32'hDEAD);
        tick();
        idle_inputs();
        vectors++;
        if (count !== CW'(8) || dut_vec() !== model_exp()) begin
            miscompares++;
            $display("FAIL push_when_full: got %h exp %h", dut_vec(), model_exp());
        end
        issue_ready = 1;
        tick();
        idle_inputs();
        vectors++;
        if (count !== CW'(7) || dispatch_ready !== 1'b0 || dut_vec() !== model_exp()) begin
            miscompares++;
            $display("FAIL count7: got %h exp %h", dut_vec(), model_exp());
        end
        push_imm(1, 32'hBEEF); issue_ready = 1;
        tick();
        idle_inputs();
        vectors++;
        if (count !== CW'(6) || dispatch_ready !== 1'b1 || dut_vec() !== model_exp()) begin
            miscompares++;
            $display("FAIL push_at_7_pop: got %h exp %h", dut_vec(), model_exp());
        end
        push_imm(2, 32'h700); issue_ready = 1;
        tick();
        idle_inputs();
        vectors++;
        if (count !== CW'(7) || dut_vec() !== model_exp()) begin
            miscompares++;
            $display("FAIL push_pop: got %h exp %h", dut_vec(), model_exp());
        end
        issue_ready = 1;
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (dut_vec() !== model_exp()) begin
                miscompares++;
                $display("FAIL drain_order[%0d]: got %h exp %h", k, dut_vec(), model_exp());
            end
            tick();
        end
        vectors++;
        if (count !== CW'(0) || issue_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drained: got count %0d iv %b exp 0 0", count, issue_valid);
        end
    endtask

    task automatic test_in_order();
        idle_inputs();
        dispatch_valid = 2'b11;
        op1_type[0] = common::OP_REG; rs1[0] = 6'd3; rs1_valid[0] = 0;
        op2_type[0] = common::OP_IMM; imm[0] = 32'h20;
        op1_type[1] = common::OP_IMM; op2_type[1] = common::OP_IMM; imm[1] = 32'h30;
        tick();
        idle_inputs(); issue_ready = 1;
        tick();
        vectors++;
        if (issue_valid !== 1'b0 || count !== CW'(2) || dut_vec() !== model_exp()) begin
            miscompares++;
            $display("FAIL in_order_block: got %h exp %h", dut_vec(), model_exp());
        end
        wb_valid = 2'b11; wb_tag[0] = 6'd3; wb_tag[1] = 6'd3;
        wb_data[0] = 32'h1; wb_data[1] = 32'h2; issue_ready = 0;
        tick();
        idle_inputs();
        vectors++;
        if (dut_vec() !== {1'b1, 1'b1, CW'(2), 32'h1, 32'h20}) begin
            miscompares++;
            $display("FAIL wb_priority: got %h exp %h", dut_vec(), {1'b1, 1'b1, CW'(2), 32'h1, 32'h20});
        end
        issue_ready = 1;
        tick(); tick();
        idle_inputs();
    endtask

`ifdef OPQ_FLUSH_EN
    task automatic test_flush();
        idle_inputs();
        push_imm(2, 32'h40); tick();
        push_imm(2, 32'h50); tick();
        vectors++;
        if (count !== CW'(4) || dut_vec() !== model_exp()) begin
            miscompares++;
            $display("FAIL flush_fill: got %h exp %h", dut_vec(), model_exp());
        end
        push_imm(2, 32'h60); issue_ready = 1; flush = 1;
        tick();
        idle_inputs();
        vectors++;
        if (count !== CW'(0) || issue_valid !== 1'b0 || dut_vec() !== model_exp()) begin
            miscompares++;
            $display("FAIL flush: got %h exp %h", dut_vec(), model_exp());
        end
    endtask
`endif

    task automatic test_random();
        int n;
        for (int cyc = 0; cyc < 600; cyc++) begin
            idle_inputs();
            rst = ($urandom_range(0, 149) == 0);
            if (FLUSH_EN) flush = ($urandom_range(0, 99) == 0);
            n = $urandom_range(0, DW);
            for (int i = 0; i < DW; i++) begin
                dispatch_valid[i] = (i < n);
                op1_type[i] = TYW'($urandom_range(0, 3));
                op2_type[i] = TYW'($urandom_range(0, 3));
                rs1[i] = TW'($urandom_range(0, 7)); rs2[i] = TW'($urandom_range(0, 7));
                rs1_valid[i] = $urandom_range(0, 2) == 0;
                rs2_valid[i] = $urandom_range(0, 2) == 0;
                imm[i] = $urandom;
            end
            for (int w = 0; w < WB; w++) begin
                wb_valid[w] = $urandom_range(0, 2) == 0;
                wb_tag[w] = TW'($urandom_range(0, 7));
                wb_data[w] = $urandom;
            end
            issue_ready = $urandom_range(0, 2) != 0;
            tick();
            vectors++;
            if (dut_vec() !== model_exp()) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h exp %h", cyc, dut_vec(), model_exp());
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_wakeup();
        test_bypass();
        test_full_wrap();
        test_in_order();
`ifdef OPQ_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
